pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register: generalises the fixed per-field ID/EX-style latch into one block with configurable data and control widths, valid/ready handshake, stall back-pressure, flush-to-bubble, and a saturating stall counter. It is instantiated between adjacent CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Control fields are forced to a programmable bubble encoding whenever the stage holds no valid instruction, so a squashed or empty slot never writes registers or memory.

## Interface
- DATA_W, 64: width of the datapath bundle (operands, PC, immediates).
- CTRL_W, 16: width of the control bundle (RegWrite, MemWrite, ALUop, ...).
- BUBBLE_CTRL, '0: control value presented when the stage is empty or flushed.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock. One clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream datapath bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- flush  in  1  squash stage contents (branch mispredict / exception).
- out_valid  out  1  stage holds a valid beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  registered datapath bundle.
- out_ctrl  out  CTRL_W  registered control bundle; BUBBLE_CTRL when out_valid=0.
- stall_cnt  out  CNT_W  cycles spent stalled (out_valid & !out_ready).

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready.
- Reset: out_valid=0, out_data=0, out_ctrl=BUBBLE_CTRL, stall_cnt=0, skid (if built) empty.
- Main register loads when empty or draining (out_ready=1); otherwise holds (stall).
- out_valid=0 forces the registered out_ctrl to BUBBLE_CTRL; out_data holds its last value when empty.
- Flush: next edge sets out_valid=0, out_ctrl=BUBBLE_CTRL, skid empty. A beat transferred in the flush cycle is consumed and discarded. Flush has priority over every load/hold. Flush while empty has no effect beyond the forcing already in place.
- Reset has priority over flush.
- stall_cnt: +1 each edge where out_valid & !out_ready; saturates at 2^CNT_W-1; cleared only by reset; flush does not clear it.
- Data and control are never reordered; each accepted, unflushed beat appears exactly once at the output.

## Timing
- Latency: 1 cycle from input transfer to out_valid (empty stage).
- Throughput: 1 beat/cycle while out_ready=1.
- Without skid: in_ready = !out_valid | out_ready (combinational through out_ready).
- With skid: in_ready is a pure register output (= skid empty); no combinational path from out_ready to in_ready.
- Simultaneous in- and out-transfer on a full main register: the new beat replaces the old in the same edge (no bubble).

## Configuration
- PIPE_SKID_EN defined: one-entry skid buffer added. A beat accepted while main is full and out_ready=0 lands in the skid; in_ready deasserts next cycle. When main drains, the skid moves into main on the same edge and in_ready reasserts the following cycle. Capacity 2 beats.
- Not defined: single register, capacity 1, combinational in_ready as above. Functional behaviour (ordering, flush, bubble forcing, counter) is otherwise identical.

## Structure
- Package pipe_pkg: per-stage control struct typedefs (id_ex_ctrl_t, ex_mem_ctrl_t, ...), their widths, and the bubble constants for each stage.
- Sub-module pipe_skid_buf: one-entry skid register with its own valid bit, instantiated only under PIPE_SKID_EN.

## Test plan
- Reset with in_valid=1, in_ctrl=16'hFFFF -> out_valid=0, out_ctrl=BUBBLE_CTRL, stall_cnt=0, in_ready=1 the cycle after reset falls.
- Stream 8 beats (data 1..8), out_ready=1 -> out_data 1..8 on consecutive cycles, 1-cycle latency, no gaps.
- Hold out_ready=0 for 5 cycles with stage full -> out_data stable, stall_cnt=5; with skid, exactly 2 beats accepted then in_ready=0; without skid, 1 beat.
- Flush asserted in the same cycle as an input transfer (data 8'hAA) while full -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL; 8'hAA never appears at output.
- CNT_W=3, hold stall 10 cycles -> stall_cnt saturates at 7, stays 7; flush does not change it.
- Random valid/ready/flush, 10k cycles, scoreboard -> output equals input sequence minus flushed beats, in order, no duplicates.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: per-stage control bundles, their widths and bubble encodings.
// Pure declarations; no latency or backpressure of its own.
package pipe_pkg;

  // Main-register update source chosen each cycle by pipe_stage_reg.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_INPUT = 2'd1,
    SEL_SKID  = 2'd2,
    SEL_EMPTY = 2'd3
  } main_sel_e;

  typedef struct packed {
    logic       pred_taken;
    logic       fetch_fault;
    logic [1:0] rsvd;
  } if_id_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] mem_size;
    logic       mem_signed;
    logic       rsvd;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_signed;
    logic       rsvd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] rsvd;
  } mem_wb_ctrl_t;

  localparam int IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

  // A bubble must never write the register file or memory; all-zero guarantees that.
  localparam if_id_ctrl_t  IF_ID_BUBBLE  = '0;
  localparam id_ex_ctrl_t  ID_EX_BUBBLE  = '0;
  localparam ex_mem_ctrl_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_ctrl_t MEM_WB_BUBBLE = '0;

  function automatic ex_mem_ctrl_t id_ex_to_ex_mem(input id_ex_ctrl_t c);
    ex_mem_ctrl_t r;
    r.reg_write  = c.reg_write;
    r.mem_to_reg = c.mem_to_reg;
    r.mem_read   = c.mem_read;
    r.mem_write  = c.mem_write;
    r.mem_size   = c.mem_size;
    r.mem_signed = c.mem_signed;
    r.rsvd       = 1'b0;
    return r;
  endfunction

  function automatic mem_wb_ctrl_t ex_mem_to_mem_wb(input ex_mem_ctrl_t c);
    mem_wb_ctrl_t r;
    r.reg_write  = c.reg_write;
    r.mem_to_reg = c.mem_to_reg;
    r.rsvd       = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register with its own valid bit, used by pipe_stage_reg under PIPE_SKID_EN.
// Latency 1 cycle; no backpressure of its own (caller gates load/unload).
module pipe_skid_buf #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              skid_vld,
  output logic [DATA_W-1:0] skid_data,
  output logic [CTRL_W-1:0] skid_ctrl
);

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      skid_vld <= 1'b0;
    end else if (load) begin
      skid_vld  <= 1'b1;
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end else if (unload) begin
      skid_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register: 1-cycle latency, flush-to-bubble, saturating stall count.
// in_ready = !out_valid | out_ready; with PIPE_SKID_EN a skid entry makes in_ready a pure register.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_vld;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CNT_W-1:0]  stall_q;
  logic              drain_ok;
  logic              in_xfer;
  main_sel_e         main_sel;

  logic              skid_vld;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // Main register may take a new value when it is empty or its beat leaves this edge.
  assign drain_ok = !main_vld || out_ready;
  assign in_xfer  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
  logic skid_load;
  logic skid_unload;

  assign in_ready    = !skid_vld;
  assign skid_load   = in_xfer && !drain_ok;
  assign skid_unload = skid_vld && drain_ok;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .load      (skid_load),
    .unload    (skid_unload),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .skid_vld  (skid_vld),
    .skid_data (skid_data),
    .skid_ctrl (skid_ctrl)
  );
`else
  assign in_ready  = drain_ok;
  assign skid_vld  = 1'b0;
  assign skid_data = '0;
  assign skid_ctrl = '0;
`endif

  // The skid entry is always older than any input beat, so it wins the main register.
  always_comb begin
    main_sel = SEL_HOLD;
    if (drain_ok) begin
      if (skid_vld) begin
        main_sel = SEL_SKID;
      end else if (in_xfer) begin
        main_sel = SEL_INPUT;
      end else begin
        main_sel = SEL_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld  <= 1'b0;
      main_data <= '0;
      main_ctrl <= BUBBLE_CTRL;
    end else if (flush) begin
      main_vld  <= 1'b0;
      main_ctrl <= BUBBLE_CTRL;
    end else begin
      case (main_sel)
        SEL_INPUT: begin
          main_vld  <= 1'b1;
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end
        SEL_SKID: begin
          main_vld  <= 1'b1;
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
        end
        SEL_EMPTY: begin
          main_vld  <= 1'b0;
          main_ctrl <= BUBBLE_CTRL;
        end
        default: begin
          main_vld  <= main_vld;
          main_data <= main_data;
          main_ctrl <= main_ctrl;
        end
      endcase
    end
  end

  // Counts stalled edges regardless of flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (main_vld && !out_ready && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign out_valid = main_vld;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, stall/flush/saturation sequences, random scoreboard.
module tb_pipe_stage_reg;

  localparam logic [15:0] BUB = 16'hB0B0;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [15:0] in_ctrl, out_ctrl, stall_cnt;

  logic       s_reset, s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
  logic [7:0] s_in_data, s_out_data;
  logic [3:0] s_in_ctrl, s_out_ctrl;
  logic [2:0] s_stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic [63:0] seq;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .BUBBLE_CTRL(BUB), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .BUBBLE_CTRL(4'h5), .CNT_W(3)) u_sat (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_ctrl(s_in_ctrl), .flush(s_flush), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic [15:0] c;
    logic        fl;
    logic        orr;
    logic        ev;
    logic [63:0] ed;
    logic [15:0] ec;
    logic [15:0] es;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cycle(input logic iv, input logic fl, input logic orr);
    logic [63:0] exp_d;
    logic [15:0] exp_c;
    in_valid  = iv;
    in_data   = seq;
    in_ctrl   = seq[15:0] ^ 16'h5A5A;
    flush     = fl;
    out_ready = orr;
    @(negedge clk);
    chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
    chk("rnd_capacity", {63'd0, sb.size() <= CAP}, 64'd1);
    if (!out_valid) chk("rnd_bubble", {48'd0, out_ctrl}, {48'd0, BUB});
    if (out_valid && out_ready && sb.size() != 0) begin
      exp_d = sb[0];
      exp_c = exp_d[15:0] ^ 16'h5A5A;
      chk("rnd_data", out_data, exp_d);
      chk("rnd_ctrl", {48'd0, out_ctrl}, {48'd0, exp_c});
      void'(sb.pop_front());
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(in_data);
    if (in_valid && in_ready) seq = seq + 64'd1;
    tick();
  endtask

  initial begin
    int acc;
    reset = 1'b1; in_valid = 1'b1; in_data = '0; in_ctrl = 16'hFFFF; flush = 1'b0; out_ready = 1'b0;
    s_reset = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_in_ctrl = '0; s_flush = 1'b0; s_out_ready = 1'b0;
    seq = 64'h1000;

    vt[0] = '{1'b1, 64'd11, 16'h0011, 1'b0, 1'b1, 1'b1, 64'd11, 16'h0011, 16'd0};
    vt[1] = '{1'b1, 64'd22, 16'h0022, 1'b0, 1'b1, 1'b1, 64'd22, 16'h0022, 16'd0};
    vt[2] = '{1'b0, 64'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 64'd22, 16'h0022, 16'd1};
    vt[3] = '{1'b0, 64'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 64'd22, BUB,      16'd1};
    vt[4] = '{1'b1, 64'd33, 16'h0033, 1'b0, 1'b0, 1'b1, 64'd33, 16'h0033, 16'd1};
    vt[5] = '{1'b0, 64'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 64'd33, BUB,      16'd2};
    vt[6] = '{1'b0, 64'd0,  16'h0000, 1'b1, 1'b1, 1'b0, 64'd33, BUB,      16'd2};
    vt[7] = '{1'b1, 64'd44, 16'h0044, 1'b1, 1'b1, 1'b0, 64'd33, BUB,      16'd2};
    vt[8] = '{1'b1, 64'd55, 16'h0055, 1'b0, 1'b1, 1'b1, 64'd55, 16'h0055, 16'd2};
    vt[9] = '{1'b0, 64'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 64'd55, BUB,      16'd2};

    // Reset with a live-looking input beat present.
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0; s_reset = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_ctrl", {48'd0, out_ctrl}, {48'd0, BUB});
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_still_empty", {63'd0, out_valid}, 64'd0);

    for (int i = 0; i < 10; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].d; in_ctrl = vt[i].c;
      flush = vt[i].fl; out_ready = vt[i].orr;
      tick();
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, {63'd0, vt[i].ev});
      chk($sformatf("vec%0d_data", i), out_data, vt[i].ed);
      chk($sformatf("vec%0d_ctrl", i), {48'd0, out_ctrl}, {48'd0, vt[i].ec});
      chk($sformatf("vec%0d_stall", i), {48'd0, stall_cnt}, {48'd0, vt[i].es});
    end

    // Stream 8 beats with out_ready held high: 1-cycle latency, no gaps.
    flush = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_ctrl = 16'(i);
      tick();
      chk($sformatf("stream%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("stream%0d_data", i), out_data, 64'(i));
    end
    in_valid = 1'b0;
    tick();

    // Stall with the stage full: count accepted beats and stalled edges.
    reset = 1'b1; tick(); reset = 1'b0;
    acc = 0; out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd100; in_ctrl = 16'h0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) acc++;
      tick();
      in_data = 64'd100 + 64'(acc); in_ctrl = 16'h0100 + 16'(acc);
      chk($sformatf("stall%0d_data", i), out_data, 64'd100);
    end
    @(negedge clk);
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stall_accepted", 64'(acc), 64'(CAP));
    chk("stall_cnt5", {48'd0, stall_cnt}, 64'd5);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("drain0_valid", {63'd0, out_valid}, 64'd1);
    chk("drain0_data", out_data, 64'd100);
    tick();
    chk("drain1_valid", {63'd0, out_valid}, {63'd0, CAP == 2});
    chk("drain_stall_cnt", {48'd0, stall_cnt}, 64'd6);
`ifdef PIPE_SKID_EN
    chk("drain1_data", out_data, 64'd101);
`endif
    tick();
    chk("drain2_valid", {63'd0, out_valid}, 64'd0);

    // Flush coinciding with an input transfer while full.
    in_valid = 1'b1; in_data = 64'd77; in_ctrl = 16'h0077; out_ready = 1'b1;
    tick();
    in_data = 64'hAA; in_ctrl = 16'h00AA; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ctrl", {48'd0, out_ctrl}, {48'd0, BUB});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush_after%0d_valid", i), {63'd0, out_valid}, 64'd0);
      chk($sformatf("flush_after%0d_noaa", i), {63'd0, out_data == 64'hAA}, 64'd0);
    end

    // Saturating counter on the narrow instance.
    s_reset = 1'b1; tick(); s_reset = 1'b0;
    s_in_valid = 1'b1; s_in_data = 8'h3C; s_in_ctrl = 4'hC; s_out_ready = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk($sformatf("sat%0d_cnt", i), {61'd0, s_stall_cnt}, (i - 1 > 7) ? 64'd7 : 64'(i - 1));
    end
    s_flush = 1'b1; tick(); s_flush = 1'b0; s_in_valid = 1'b0;
    chk("sat_flush_cnt", {61'd0, s_stall_cnt}, 64'd7);
    chk("sat_flush_valid", {63'd0, s_out_valid}, 64'd0);
    chk("sat_flush_ctrl", {60'd0, s_out_ctrl}, 64'h5);
    tick(); tick();
    chk("sat_hold_cnt", {61'd0, s_stall_cnt}, 64'd7);

    // Random traffic against the queue scoreboard.
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; tick(); reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 10000; i++) begin
      rnd_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) rnd_cycle(1'b0, 1'b0, 1'b1);
    chk("rnd_final_empty", 64'(sb.size()), 64'd0);
    chk("rnd_final_valid", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
